a10_sata_xcvr_link_seq: RTL and testbench
=========================================

// Module: a10_sata_xcvr_link_seq
// PURPOSE
//  Supervises the Arria 10 SATA transceiver reset controller, one level above it. Drives that controller's reset
//  input and consumes its tx_ready/rx_ready. Times out stalled bring-ups, retries a bounded number of times and
//  re-resets the transceiver on loss of CDR lock. Presents a single clean link_ready/fail status to the SATA PHY
//  layer. Shares the controller's clock.
// PARAMETERS
//  RST_HOLD    16       cycles xcvr_reset held high per attempt (>=1)
//  TX_TIMEOUT  100000   max cycles waiting for tx_ready after xcvr_reset release
//  RX_TIMEOUT  1000000  max cycles waiting for rx_ready after tx_ready seen
//  LOL_FILTER  64       consecutive cycles rx lock must be low in READY to declare loss (>=1)
//  MAX_RETRY   7        failed attempts tolerated before FAIL (>=1)
// PORTS
//  clock               in   1  block clock, same as reset controller clock
//  reset               in   1  asynchronous, active-low reset
//  restart             in   1  sync pulse/level: abort and restart sequence, clears retry state and fail
//  tx_ready            in   1  from reset controller, clock domain
//  rx_ready            in   1  from reset controller, clock domain
//  rx_is_lockedtodata  in   1  from transceiver, asynchronous; 2-flop synchronised internally
//  xcvr_reset          out  1  active-high reset to the reset controller
//  link_ready          out  1  transceiver up and locked
//  fail                out  1  MAX_RETRY attempts exhausted; sticky until restart or reset
//  retry_cnt           out  W  failed attempts since last READY/restart, W=$clog2(MAX_RETRY+1)
//  drop_cnt            out  8  link drops from READY, saturates at 255, cleared only by reset
// BEHAVIOUR
//  Reset values: state=HOLD, xcvr_reset=1, link_ready=0, fail=0, retry_cnt=0, drop_cnt=0, all counters 0.
//  All outputs are registered.
//  HOLD:    xcvr_reset=1. Timer counts to RST_HOLD-1, then -> WAIT_TX. xcvr_reset is high exactly RST_HOLD cycles
//           after reset/restart deassertion.
//  WAIT_TX: xcvr_reset=0.
//           - tx_ready=1 -> WAIT_RX.
//           - Otherwise, timer==TX_TIMEOUT-1 -> timeout.
//           - tx_ready wins over timeout in the same cycle.
//  WAIT_RX: timer restarts at 0.
//           - tx_ready and rx_ready both 1 -> READY.
//           - tx_ready drop -> timeout immediately.
//           - timer==RX_TIMEOUT-1 -> timeout.
//  Timeout: retry_cnt+1.
//           - New value < MAX_RETRY -> HOLD.
//           - New value == MAX_RETRY -> FAIL.
//  READY:   link_ready=1 starting the cycle after entry. retry_cnt cleared on entry.
//           - LOL filter counter increments while rx_lock_sync==0; any 1 clears it.
//           - Counter reaching LOL_FILTER-1 -> HOLD, drop_cnt+1.
//           - tx_ready or rx_ready low for one cycle -> HOLD, drop_cnt+1, no filtering.
//           - Drops do not count as retries.
//  FAIL:    xcvr_reset=1, link_ready=0, fail=1. State held until restart.
//  restart=1 in any state:
//           - Next state is HOLD; timer, LOL counter, retry_cnt and fail are cleared; xcvr_reset=1.
//           - While restart stays high, the timer is held at 0.
//           - The HOLD count begins the cycle restart drops.
//           - restart overrides all other transitions in that cycle.
//  link_ready falls in the same cycle xcvr_reset rises. The two are never both 1.
//  Timer width is $clog2 of the largest of RST_HOLD, TX_TIMEOUT and RX_TIMEOUT. The timer never wraps; it is
//  reset on every state change.
//  Asynchronous reset mid-sequence returns every register to its reset value immediately.
// STRUCTURE
//  Shared package/header a10_sata_xcvr_pkg:
//   - state encoding localparams HOLD=0, WAIT_TX=1, WAIT_RX=2, READY=3, FAIL=4 (3 bits)
//   - drop counter width constant (8)
//  Sub-module a10_sata_bit_sync: 2-flop synchroniser with async active-low reset, init 0, used for
//  rx_is_lockedtodata.
//  The FSM, timer, LOL filter and counters stay in this module.
// TESTING
//  Bench params: RST_HOLD=4, TX_TIMEOUT=20, RX_TIMEOUT=30, LOL_FILTER=3, MAX_RETRY=2.
//  1. Release reset; assert tx_ready at cycle 6 and rx_ready/lock at cycle 10 -> xcvr_reset high exactly 4 cycles;
//     link_ready=1 after READY entry; retry_cnt=0.
//  2. tx_ready never asserted -> xcvr_reset pulses 4 cycles twice, 20 cycles apart; then fail=1, retry_cnt=2,
//     xcvr_reset=1 held.
//  3. In READY, drop lock 2 cycles then restore -> no change. Drop lock 3 cycles -> link_ready=0, xcvr_reset=1,
//     drop_cnt=1.
//  4. In READY, rx_ready low 1 cycle -> HOLD next cycle, drop_cnt+1, retry_cnt stays 0.
//  5. In FAIL, pulse restart 1 cycle -> fail=0, retry_cnt=0, 4-cycle xcvr_reset pulse, normal bring-up completes.
//  6. Assert reset mid-WAIT_RX and tx_ready+timer-expiry in the same cycle -> reset values immediately; ready wins
//     over timeout.

Source files
------------

// File: rtl/a10_sata_xcvr_pkg.sv
// ============================================================================
// Module : a10_sata_xcvr_pkg
// Brief  : Shared state encoding, widths and sizing helpers for the SATA
//          transceiver link sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package a10_sata_xcvr_pkg;

    localparam int STATE_W    = 3;
    localparam int DROP_CNT_W = 8;

    localparam logic [STATE_W-1:0] HOLD    = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_TX = 3'd1;
    localparam logic [STATE_W-1:0] WAIT_RX = 3'd2;
    localparam logic [STATE_W-1:0] READY   = 3'd3;
    localparam logic [STATE_W-1:0] FAIL    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = HOLD,
        ST_WAIT_TX = WAIT_TX,
        ST_WAIT_RX = WAIT_RX,
        ST_READY   = READY,
        ST_FAIL    = FAIL
    } link_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/a10_sata_bit_sync.sv
// ============================================================================
// Module : a10_sata_bit_sync
// Brief  : Two-flop synchroniser for a single asynchronous level, resets to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module a10_sata_bit_sync
    import a10_sata_xcvr_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/a10_sata_xcvr_link_seq.sv
// ============================================================================
// Module : a10_sata_xcvr_link_seq
// Brief  : Supervises the transceiver reset controller: timed bring-up,
//          bounded retries, loss-of-lock recovery and a clean link status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module a10_sata_xcvr_link_seq
    import a10_sata_xcvr_pkg::*;
#(
    parameter int RST_HOLD   = 16,
    parameter int TX_TIMEOUT = 100000,
    parameter int RX_TIMEOUT = 1000000,
    parameter int LOL_FILTER = 64,
    parameter int MAX_RETRY  = 7
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               restart,
    input  logic                               tx_ready,
    input  logic                               rx_ready,
    input  logic                               rx_is_lockedtodata,
    output logic                               xcvr_reset,
    output logic                               link_ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [DROP_CNT_W-1:0]              drop_cnt
);

    localparam int TIMER_W = cnt_w(max3(RST_HOLD, TX_TIMEOUT, RX_TIMEOUT));
    localparam int LOL_W   = cnt_w(LOL_FILTER);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(RST_HOLD - 1);
    localparam logic [TIMER_W-1:0] TX_LAST   = TIMER_W'(TX_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RX_LAST   = TIMER_W'(RX_TIMEOUT - 1);
    localparam logic [LOL_W-1:0]   LOL_LAST  = LOL_W'(LOL_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    link_state_t            state;
    link_state_t            state_nxt;
    logic [TIMER_W-1:0]     timer;
    logic [TIMER_W-1:0]     timer_nxt;
    logic [LOL_W-1:0]       lol_cnt;
    logic [LOL_W-1:0]       lol_nxt;
    logic [RETRY_W-1:0]     retry_nxt;
    logic [RETRY_W-1:0]     retry_inc;
    logic [DROP_CNT_W-1:0]  drop_nxt;
    logic                   timeout;
    logic                   link_drop;
    logic                   lock_sync;

    a10_sata_bit_sync u_lock_sync (
        .clock (clock),
        .reset (reset),
        .din   (rx_is_lockedtodata),
        .dout  (lock_sync)
    );

    assign retry_inc = retry_cnt + RETRY_W'(1);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lol_nxt   = '0;
        retry_nxt = retry_cnt;
        drop_nxt  = drop_cnt;
        timeout   = 1'b0;
        link_drop = 1'b0;

        if (restart) begin
            state_nxt = ST_HOLD;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (timer == HOLD_LAST) state_nxt = ST_WAIT_TX;
                    else                    timer_nxt = timer + TIMER_W'(1);
                end
                ST_WAIT_TX: begin
                    if (tx_ready)             state_nxt = ST_WAIT_RX;
                    else if (timer == TX_LAST) timeout  = 1'b1;
                    else                       timer_nxt = timer + TIMER_W'(1);
                end
                ST_WAIT_RX: begin
                    if (tx_ready && rx_ready) begin
                        state_nxt = ST_READY;
                        retry_nxt = '0;
                    end else if (!tx_ready || timer == RX_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        timer_nxt = timer + TIMER_W'(1);
                    end
                end
                ST_READY: begin
                    // Ready handshakes dropping are trusted outright; only
                    // CDR lock loss is filtered against glitches.
                    if (!tx_ready || !rx_ready) begin
                        link_drop = 1'b1;
                    end else if (!lock_sync) begin
                        if (lol_cnt == LOL_LAST) link_drop = 1'b1;
                        else                     lol_nxt   = lol_cnt + LOL_W'(1);
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_HOLD;
                end
            endcase

            if (timeout) begin
                retry_nxt = retry_inc;
                state_nxt = (retry_inc >= RETRY_MAX) ? ST_FAIL : ST_HOLD;
            end

            if (link_drop) begin
                state_nxt = ST_HOLD;
                drop_nxt  = (drop_cnt == '1) ? drop_cnt : drop_cnt + DROP_CNT_W'(1);
            end
        end

        if (state_nxt != state) timer_nxt = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_HOLD;
            timer      <= '0;
            lol_cnt    <= '0;
            retry_cnt  <= '0;
            drop_cnt   <= '0;
            xcvr_reset <= 1'b1;
            link_ready <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            lol_cnt    <= lol_nxt;
            retry_cnt  <= retry_nxt;
            drop_cnt   <= drop_nxt;
            xcvr_reset <= (state_nxt == ST_HOLD) || (state_nxt == ST_FAIL);
            link_ready <= (state_nxt == ST_READY);
            fail       <= (state_nxt == ST_FAIL);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_a10_sata_xcvr_link_seq.sv
// ============================================================================
// Module : tb_a10_sata_xcvr_link_seq
// Brief  : Directed bench; expected outputs are queued per cycle and a
//          negedge monitor pops and compares them.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_a10_sata_xcvr_link_seq;

    logic       clock;
    logic       reset;
    logic       restart;
    logic       tx_ready;
    logic       rx_ready;
    logic       lock;
    logic       xcvr_reset;
    logic       link_ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] drop_cnt;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       xr;
        logic       lr;
        logic       fl;
        logic [1:0] rc;
        logic [7:0] dc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    a10_sata_xcvr_link_seq #(
        .RST_HOLD   (4),
        .TX_TIMEOUT (20),
        .RX_TIMEOUT (30),
        .LOL_FILTER (3),
        .MAX_RETRY  (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .restart            (restart),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .rx_is_lockedtodata (lock),
        .xcvr_reset         (xcvr_reset),
        .link_ready         (link_ready),
        .fail               (fail),
        .retry_cnt          (retry_cnt),
        .drop_cnt           (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        n_checks++;
        if (link_ready && xcvr_reset) begin
            n_fail++;
            $display("FAIL exclusive @%0d: link_ready=%b xcvr_reset=%b, required not both 1",
                     cyc, link_ready, xcvr_reset);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc != cyc ||
                {xcvr_reset, link_ready, fail, retry_cnt, drop_cnt} !== {e.xr, e.lr, e.fl, e.rc, e.dc}) begin
                n_fail++;
                $display("FAIL %s @%0d: got xr=%b lr=%b fail=%b retry=%0d drop=%0d, expected xr=%b lr=%b fail=%b retry=%0d drop=%0d",
                         e.name, cyc, xcvr_reset, link_ready, fail, retry_cnt, drop_cnt,
                         e.xr, e.lr, e.fl, e.rc, e.dc);
            end
        end
    end

    task automatic chk(input string name, input logic xr, input logic lr, input logic fl,
                       input logic [1:0] rc, input logic [7:0] dc);
        exp_t x;
        x.cyc  = cyc;
        x.name = name;
        x.xr   = xr;
        x.lr   = lr;
        x.fl   = fl;
        x.rc   = rc;
        x.dc   = dc;
        exp_q.push_back(x);
    endtask

    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    int b0, a, b, c, d, e0, f;

    initial begin
        reset    = 1'b0;
        restart  = 1'b0;
        tx_ready = 1'b0;
        rx_ready = 1'b0;
        lock     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("in_reset", 1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Bring-up: tx at +6, rx/lock at +10
        b0 = cyc;
        chk("rst_release", 1, 0, 0, 0, 0);
        at(b0 + 3);  chk("hold_last",   1, 0, 0, 0, 0);
        at(b0 + 4);  chk("hold_exit",   0, 0, 0, 0, 0);
        at(b0 + 6);  tx_ready = 1'b1;
        at(b0 + 10); rx_ready = 1'b1; lock = 1'b1;
                     chk("wait_rx",     0, 0, 0, 0, 0);
        at(b0 + 11); chk("ready",       0, 1, 0, 0, 0);

        // Lock loss: 2 cycles filtered, 3 cycles drops the link
        a = b0 + 15;
        at(a);       lock = 1'b0;
        at(a + 2);   lock = 1'b1;
        at(a + 6);   chk("lol_short",   0, 1, 0, 0, 0);
        b = a + 8;
        at(b);       lock = 1'b0;
        at(b + 3);   lock = 1'b1;
        at(b + 4);   chk("lol_pre",     0, 1, 0, 0, 0);
        at(b + 5);   chk("lol_drop",    1, 0, 0, 0, 1);
        at(b + 11);  chk("rebring1",    0, 1, 0, 0, 1);

        // rx_ready glitch drops the link without filtering
        c = b + 14;
        at(c);       rx_ready = 1'b0;
                     chk("rx_glitch",   0, 1, 0, 0, 1);
        at(c + 1);   rx_ready = 1'b1;
                     chk("rx_drop",     1, 0, 0, 0, 2);
        at(c + 7);   chk("rebring2",    0, 1, 0, 0, 2);

        // tx_ready never comes: two timeouts then FAIL
        d = c + 10;
        at(d);       tx_ready = 1'b0; rx_ready = 1'b0;
                     chk("tx_loss",     0, 1, 0, 0, 2);
        at(d + 1);   chk("try1_hold",   1, 0, 0, 0, 3);
        at(d + 4);   chk("try1_last",   1, 0, 0, 0, 3);
        at(d + 5);   chk("try1_wait",   0, 0, 0, 0, 3);
        at(d + 24);  chk("try1_expire", 0, 0, 0, 0, 3);
        at(d + 25);  chk("try2_hold",   1, 0, 0, 1, 3);
        at(d + 29);  chk("try2_wait",   0, 0, 0, 1, 3);
        at(d + 48);  chk("try2_expire", 0, 0, 0, 1, 3);
        at(d + 49);  chk("failed",      1, 0, 1, 2, 3);
        at(d + 60);  chk("fail_hold",   1, 0, 1, 2, 3);

        // Restart pulse out of FAIL, then normal bring-up
        e0 = d + 62;
        at(e0);      restart = 1'b1;
                     chk("restart_in",  1, 0, 1, 2, 3);
        at(e0 + 1);  restart = 1'b0;
                     chk("restart_clr", 1, 0, 0, 0, 3);
        at(e0 + 4);  chk("rs_hold_end", 1, 0, 0, 0, 3);
        at(e0 + 5);  chk("rs_wait_tx",  0, 0, 0, 0, 3);
        at(e0 + 6);  tx_ready = 1'b1; rx_ready = 1'b1;
        at(e0 + 8);  chk("rs_ready",    0, 1, 0, 0, 3);

        // tx_ready on the timeout cycle wins; then async reset mid WAIT_RX
        f = e0 + 12;
        at(f);       restart = 1'b1; tx_ready = 1'b0; rx_ready = 1'b0;
                     chk("ready_rs",    0, 1, 0, 0, 3);
        at(f + 1);   restart = 1'b0;
                     chk("rs2_hold",    1, 0, 0, 0, 3);
        at(f + 5);   chk("rs2_wait_tx", 0, 0, 0, 0, 3);
        at(f + 24);  tx_ready = 1'b1;
                     chk("tx_at_limit", 0, 0, 0, 0, 3);
        at(f + 25);  chk("tx_wins",     0, 0, 0, 0, 3);
        at(f + 27);  reset = 1'b0;
                     #1;
                     chk("async_rst",   1, 0, 0, 0, 0);
        at(f + 29);  chk("rst_held",    1, 0, 0, 0, 0);
        at(f + 30);  reset = 1'b1; tx_ready = 1'b0;
                     chk("rst_again",   1, 0, 0, 0, 0);
        at(f + 33);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
